fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
- REQ-001 ADDR_W, 64, PC and instruction-address width.
- REQ-002 INSTR_W, 32, instruction width.
- REQ-003 DEPTH, 4, fetch-queue entries; power of two, at least 2.
- REQ-004 RESET_PC, 0, PC value loaded on reset.
- REQ-005 One clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
- REQ-006 imem_req out 1: instruction-memory read request this cycle.
- REQ-007 imem_addr out ADDR_W: read address; valid when imem_req=1.
- REQ-008 imem_data in INSTR_W: read data for the request of the previous cycle, fixed 1-cycle latency, no valid strobe.
- REQ-009 redirect_valid in 1: execute-stage branch-resolution redirect.
- REQ-010 redirect_pc in ADDR_W: redirect target; bits [1:0] ignored and treated as 0.
- REQ-011 out_valid out 1, out_ready in 1: valid/ready handshake to decode.
- REQ-012 out_instr out INSTR_W, out_pc out ADDR_W, out_pred out 1: head instruction, its address, and a predicted-taken flag.

Function
- REQ-013 The fetch PC register increments by 4 per issued request, modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is not an error.
- REQ-014 A request issues when (queue count + in-flight) < DEPTH and no redirect is asserted this cycle. At most one request is in flight.
- REQ-015 A response is written next cycle into the queue tail with its PC tag, unless it has been killed.
- REQ-016 out_valid = queue not empty. Pop on out_valid && out_ready. Data is held stable while out_valid && !out_ready.
- REQ-017 Push and pop in the same cycle on a full queue are legal: count is unchanged and no data is lost.
- REQ-018 On redirect_valid: flush the queue (count = 0), kill any in-flight response, load PC = {redirect_pc[ADDR_W-1:2],2'b00}. The first request to the new PC issues the next cycle.
- REQ-019 Redirect and pop in the same cycle: the pop completes and the flush wins. Redirect and push in the same cycle: the push is discarded.
- REQ-020 Back-to-back redirects: the last one wins, and each one kills the in-flight response.
- REQ-021 FSM states: RUN (normal issue) and DRAIN (a response is in flight that must be dropped). A redirect with a request in flight enters DRAIN. DRAIN returns to RUN after 1 cycle. Issue is permitted in DRAIN subject to REQ-014.
- REQ-022 Queue occupancy never exceeds DEPTH, and a pop never occurs from an empty queue.

Reset
- REQ-023 On reset: PC = RESET_PC, count = 0, in-flight = 0, FSM = RUN, imem_req = 0, out_valid = 0, out_pred = 0.
- REQ-024 Reset asserted mid-operation discards all queued and in-flight instructions. The first request issues on the first cycle after reset deasserts.

Configuration
- REQ-025 Macro FETCH_PREDICT_EN.
- REQ-026 With FETCH_PREDICT_EN defined: when a pushed response has instr[31:26] = 6'b000101 (unconditional B), it is enqueued with out_pred = 1. PC is then loaded with tagPC + (sign-extended instr[25:0] << 2), and any in-flight younger response is killed as in REQ-018.
- REQ-027 With FETCH_PREDICT_EN undefined: fetch is purely sequential, out_pred is tied 0, and B is resolved only via redirect.
- REQ-028 An external redirect in the same cycle as an internal prediction takes priority.

Structure
- REQ-029 Shared package cpu_pkg holds: the INSTR_W default, the OP_B opcode constant, the RESET_PC default, and the fetch-FSM state enum.
- REQ-030 The queue is a separate sub-module fetch_fifo (parametrised DEPTH and width, with a synchronous flush input). fetch_unit owns the PC, the FSM and the kill logic.

Verification
- REQ-031 Reset with RESET_PC=0x100 and out_ready=1 -> requests at 0x100, 0x104, 0x108; first out_valid in cycle 2 after reset release with out_pc=0x100.
- REQ-032 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued; queue holds 0x100..0x10C; head stable; no further imem_req until a pop.
- REQ-033 redirect_pc=0x2003 while a request is in flight -> queue empties; the in-flight word is not delivered; the next out_pc is 0x2000.
- REQ-034 Redirect coinciding with a pop and a push -> the pop is accepted; the pushed word is dropped; the next delivered out_pc equals the redirect target.
- REQ-035 PC wrap: RESET_PC = 2^64-8 -> out_pc sequence 0xFFFF_FFFF_FFFF_FFF8, 0xFFFF_FFFF_FFFF_FFFC, 0x0.
- REQ-036 FETCH_PREDICT_EN defined, B with imm26 = -2 at 0x40 -> out_pred=1 at 0x40; the next delivered out_pc is 0x38; the word at 0x44 is never delivered.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU front end (fetch unit and its queue).
package cpu_pkg;

    localparam int          INSTR_W_DEF  = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;
    localparam logic [5:0]  OP_B         = 6'b000101;

    typedef enum logic {
        FETCH_RUN,
        FETCH_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two fetch queue with synchronous flush; pop of an empty queue is ignored.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full queue can still accept a push.
    assign do_push = push && (!full || pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request, kill FSM, fetch queue.
// Optional static B prediction is enabled by defining FETCH_PREDICT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               out_pred
);

    localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_PREDICT_EN
    localparam int EW = INSTR_W + ADDR_W + 1;
`else
    localparam int EW = INSTR_W + ADDR_W;
`endif

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] inflight_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] branch_target;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic              take_branch;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     rdata;

    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign occupancy       = {1'b0, fifo_count} + (CW+1)'(inflight);
    assign issue           = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    // The response arriving during DRAIN belongs to a killed request.
    assign push            = inflight && (state == FETCH_RUN) && !redirect_valid;
    assign out_valid       = !fifo_empty && !reset;
    assign pop             = out_valid && out_ready;
    assign imem_req        = issue;
    assign imem_addr       = pc;

`ifdef FETCH_PREDICT_EN
    logic stored_pred;

    assign take_branch   = push && (imem_data[31:26] == OP_B);
    assign branch_target = inflight_pc + {{(ADDR_W-28){imem_data[25]}}, imem_data[25:0], 2'b00};
    assign wdata         = {take_branch, inflight_pc, imem_data};
    assign {stored_pred, out_pc, out_instr} = rdata;
    assign out_pred      = out_valid && stored_pred;
`else
    assign take_branch   = 1'b0;
    assign branch_target = '0;
    assign wdata         = {inflight_pc, imem_data};
    assign {out_pc, out_instr} = rdata;
    assign out_pred      = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // External redirect outranks an internal prediction made in the same cycle.
    always_comb begin
        pc_next    = pc;
        state_next = FETCH_RUN;
        if (issue) begin
            pc_next = pc + ADDR_W'(4);
        end
        if (redirect_valid) begin
            pc_next = redirect_target;
            if (inflight) begin
                state_next = FETCH_DRAIN;
            end
        end else if (take_branch) begin
            pc_next = branch_target;
            if (issue) begin
                state_next = FETCH_DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a delivered-PC-sequence model. Define FETCH_PREDICT_EN to cover prediction.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          ADDR_W = 64;
    localparam int          INSTR_W = 32;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h100;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data = '0;
    logic               redirect_valid = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_pred;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred       (out_pred)
    );

    // Instruction image: never an OP_B except a B with imm26 = -2 at 0x40 in predict builds.
    function automatic logic [31:0] word(input logic [63:0] a);
        logic [31:0] w;
        w = {6'b111000, a[27:2] ^ a[53:28]};
`ifdef FETCH_PREDICT_EN
        if (a == 64'h40) w = {OP_B, 26'h3FF_FFFE};
`endif
        return w;
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_data <= word(imem_addr);
    end

    task automatic applyStimulus(input logic rst, input logic rdy, input logic rv, input logic [63:0] rpc);
        @(negedge clk);
        reset          = rst;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        vectors++;
        if ({imem_req, out_valid, out_pred} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got req/valid/pred=%b, expected 000", {imem_req, out_valid, out_pred});
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h100 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_cycle0: got req=%b addr=%h valid=%b, expected 1 100 0", imem_req, imem_addr, out_valid);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h104 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_cycle1: got req=%b addr=%h valid=%b, expected 1 104 0", imem_req, imem_addr, out_valid);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instr !== word(64'h100) || imem_addr !== 64'h108) begin
            miscompares++;
            $display("[TB] FAIL reset_cycle2: got valid=%b pc=%h instr=%h addr=%h, expected 1 100 %h 108",
                     out_valid, out_pc, out_instr, imem_addr, word(64'h100));
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] addrs[$];
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0);
            if (imem_req === 1'b1) addrs.push_back(imem_addr);
            if (k >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pc !== 64'h100) begin
                    miscompares++;
                    $display("[TB] FAIL bp_head_stable[%0d]: got valid=%b pc=%h, expected 1 100", k, out_valid, out_pc);
                end
            end
            if (k >= 4) begin
                vectors++;
                if (imem_req !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL bp_no_req[%0d]: got req=%b, expected 0", k, imem_req);
                end
            end
        end
        vectors++;
        if (addrs.size() != 4) begin
            miscompares++;
            $display("[TB] FAIL bp_req_count: got %0d requests, expected 4", addrs.size());
        end
        for (int i = 0; i < addrs.size() && i < 4; i++) begin
            vectors++;
            if (addrs[i] !== 64'h100 + 64'(4 * i)) begin
                miscompares++;
                $display("[TB] FAIL bp_req_addr[%0d]: got %h, expected %h", i, addrs[i], 64'h100 + 64'(4 * i));
            end
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 64'h100 + 64'(4 * k) || out_instr !== word(64'h100 + 64'(4 * k))) begin
                miscompares++;
                $display("[TB] FAIL bp_drain[%0d]: got valid=%b pc=%h, expected 1 %h", k, out_valid, out_pc, 64'h100 + 64'(4 * k));
            end
            if (k == 0) begin
                vectors++;
                if (imem_req !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL bp_req_at_pop: got req=%b, expected 0", imem_req);
                end
            end
            if (k == 1) begin
                vectors++;
                if (imem_req !== 1'b1 || imem_addr !== 64'h110) begin
                    miscompares++;
                    $display("[TB] FAIL bp_req_after_pop: got req=%b addr=%h, expected 1 110", imem_req, imem_addr);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_hold: got valid=%b req=%b, expected 0 0", out_valid, imem_req);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_cycle0: got req=%b addr=%h valid=%b, expected 1 100 0", imem_req, imem_addr, out_valid);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_discard: got valid=%b, expected 0", out_valid);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== RST_PC) begin
            miscompares++;
            $display("[TB] FAIL midreset_first: got valid=%b pc=%h, expected 1 100", out_valid, out_pc);
        end
    endtask

    task automatic test_redirect();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h2003);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL redir_no_issue: got req=%b, expected 0", imem_req);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
            miscompares++;
            $display("[TB] FAIL redir_flush: got valid=%b req=%b addr=%h, expected 0 1 2000", out_valid, imem_req, imem_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL redir_killed: got valid=%b pc=%h, expected valid 0", out_valid, out_pc);
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 64'h2000 + 64'(4 * k)) begin
                miscompares++;
                $display("[TB] FAIL redir_target[%0d]: got valid=%b pc=%h, expected 1 %h", k, out_valid, out_pc, 64'h2000 + 64'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_pop_push();
        bit found = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h3000);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h100) begin
            miscompares++;
            $display("[TB] FAIL rpp_pop: got valid=%b pc=%h, expected 1 100", out_valid, out_pc);
        end
        for (int k = 0; k < 10 && !found; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            if (out_valid === 1'b1) begin
                found = 1;
                vectors++;
                if (out_pc !== 64'h3000) begin
                    miscompares++;
                    $display("[TB] FAIL rpp_next: got pc=%h, expected 3000", out_pc);
                end
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rpp_timeout: no delivery within 10 cycles, expected pc 3000");
        end
    endtask

    task automatic test_wrap();
        logic [63:0] expq[3];
        int n = 0;
        expq[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        expq[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        expq[2] = 64'h0;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int k = 0; k < 20 && n < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_pc !== expq[n] || out_instr !== word(expq[n])) begin
                    miscompares++;
                    $display("[TB] FAIL wrap[%0d]: got pc=%h instr=%h, expected %h %h", n, out_pc, out_instr, expq[n], word(expq[n]));
                end
                n++;
            end
        end
        if (n < 3) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wrap_timeout: got %0d deliveries, expected 3", n);
        end
    endtask

`ifdef FETCH_PREDICT_EN
    task automatic test_predict();
        logic [63:0] expq[5];
        logic        predq[5];
        int n = 0;
        expq  = '{64'h3C, 64'h40, 64'h38, 64'h3C, 64'h40};
        predq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h3C);
        for (int k = 0; k < 40 && n < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_pc !== expq[n] || out_pred !== predq[n]) begin
                    miscompares++;
                    $display("[TB] FAIL predict[%0d]: got pc=%h pred=%b, expected %h %b", n, out_pc, out_pred, expq[n], predq[n]);
                end
                n++;
            end
        end
        if (n < 5) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL predict_timeout: got %0d deliveries, expected 5", n);
        end
    endtask
`endif

    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] rpc;
        logic [31:0] w;
        logic        rdy;
        logic        rv;
        logic        exp_pred;
        int          delivered = 0;
        exp_pc = RST_PC;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int c = 0; c < 1500; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = {$urandom(), $urandom()};
            applyStimulus(1'b0, rdy, rv, rpc);
            if (rv) begin
                vectors++;
                if (imem_req !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rand_req_on_redirect[%0d]: got req=%b, expected 0", c, imem_req);
                end
            end
            if (out_valid === 1'b1 && rdy) begin
                w = word(exp_pc);
`ifdef FETCH_PREDICT_EN
                exp_pred = (w[31:26] == OP_B);
`else
                exp_pred = 1'b0;
`endif
                vectors++;
                if (out_pc !== exp_pc || out_instr !== w || out_pred !== exp_pred) begin
                    miscompares++;
                    $display("[TB] FAIL rand_deliver[%0d]: got pc=%h instr=%h pred=%b, expected %h %h %b",
                             c, out_pc, out_instr, out_pred, exp_pc, w, exp_pred);
                end
                if (exp_pred) exp_pc = exp_pc + 64'($signed(w[25:0])) * 64'd4;
                else          exp_pc = exp_pc + 64'd4;
                delivered++;
            end
            if (rv) exp_pc = rpc & ~64'h3;
        end
        vectors++;
        if (delivered < 200) begin
            miscompares++;
            $display("[TB] FAIL rand_throughput: got %0d deliveries, expected at least 200", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_mid_reset();
        test_redirect();
        test_redirect_pop_push();
        test_wrap();
`ifdef FETCH_PREDICT_EN
        test_predict();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
